// File: rtl/rv_alu_arbiter.sv
// Round-robin arbiter sharing one RV32 ALU among NTHREADS threads, with issue and response stages.
// Define RV_ALU_ARB_STATS_EN to build the saturating stall counter on stat_stall_cnt.
module rv_alu_arbiter #(
  parameter int NTHREADS = 4,
  parameter int TID_W    = 2,
  parameter int XLEN     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NTHREADS-1:0]      req,
  input  logic [NTHREADS*7-1:0]    req_opcode,
  input  logic [NTHREADS*3-1:0]    req_funct3,
  input  logic [NTHREADS*7-1:0]    req_funct7,
  input  logic [NTHREADS*XLEN-1:0] req_op1,
  input  logic [NTHREADS*XLEN-1:0] req_op2,
  output logic [NTHREADS-1:0]      gnt,
  output logic [6:0]               alu_opcode,
  output logic [2:0]               alu_funct3,
  output logic [6:0]               alu_funct7,
  output logic [XLEN-1:0]          alu_op1,
  output logic [XLEN-1:0]          alu_op2,
  input  logic [XLEN-1:0]          alu_rez,
  output logic                     rsp_valid,
  output logic [TID_W-1:0]         rsp_tid,
  output logic [XLEN-1:0]          rsp_data,
  input  logic                     rsp_ready,
  output logic [31:0]              stat_stall_cnt
);

  logic [6:0]      opc_a [NTHREADS];
  logic [2:0]      f3_a  [NTHREADS];
  logic [6:0]      f7_a  [NTHREADS];
  logic [XLEN-1:0] op1_a [NTHREADS];
  logic [XLEN-1:0] op2_a [NTHREADS];

  for (genvar g = 0; g < NTHREADS; g++) begin : g_unpack
    assign opc_a[g] = req_opcode[7*g +: 7];
    assign f3_a[g]  = req_funct3[3*g +: 3];
    assign f7_a[g]  = req_funct7[7*g +: 7];
    assign op1_a[g] = req_op1[XLEN*g +: XLEN];
    assign op2_a[g] = req_op2[XLEN*g +: XLEN];
  end

  logic             stall;
  logic             found;
  logic [TID_W-1:0] winner;
  logic [TID_W-1:0] cand;
  logic [TID_W-1:0] rr_last;

  logic             iss_valid;
  logic [TID_W-1:0] iss_tid;
  logic [6:0]       iss_opcode;
  logic [2:0]       iss_funct3;
  logic [6:0]       iss_funct7;
  logic [XLEN-1:0]  iss_op1;
  logic [XLEN-1:0]  iss_op2;

  assign stall = rsp_valid & ~rsp_ready;

  // Search starts just after the last winner and wraps modulo NTHREADS.
  always_comb begin
    gnt    = '0;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    if (!rst && !stall) begin
      for (int i = 1; i <= NTHREADS; i++) begin
        cand = TID_W'((int'(rr_last) + i) % NTHREADS);
        if (!found && req[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
    if (found) gnt[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last    <= TID_W'(NTHREADS - 1);
      iss_valid  <= 1'b0;
      iss_tid    <= '0;
      iss_opcode <= '0;
      iss_funct3 <= '0;
      iss_funct7 <= '0;
      iss_op1    <= '0;
      iss_op2    <= '0;
      rsp_valid  <= 1'b0;
      rsp_tid    <= '0;
      rsp_data   <= '0;
    end else if (!stall) begin
      rsp_valid <= iss_valid;
      rsp_tid   <= iss_tid;
      if (iss_valid) rsp_data <= alu_rez;
      iss_valid <= found;
      if (found) begin
        rr_last    <= winner;
        iss_tid    <= winner;
        iss_opcode <= opc_a[winner];
        iss_funct3 <= f3_a[winner];
        iss_funct7 <= f7_a[winner];
        iss_op1    <= op1_a[winner];
        iss_op2    <= op2_a[winner];
      end
    end
  end

  assign alu_opcode = iss_opcode;
  assign alu_funct3 = iss_funct3;
  assign alu_funct7 = iss_funct7;
  assign alu_op1    = iss_op1;
  assign alu_op2    = iss_op2;

`ifdef RV_ALU_ARB_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && |req && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_stall_cnt = stall_cnt;
`else
  assign stat_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rv_alu_arbiter.sv
// Directed table-driven bench for rv_alu_arbiter with a stand-in ALU; plus an async-reset sequence.
module tb_rv_alu_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req = '0;
  logic [27:0]  req_opcode;
  logic [11:0]  req_funct3;
  logic [27:0]  req_funct7;
  logic [127:0] req_op1;
  logic [127:0] req_op2;
  logic [3:0]   gnt;
  logic [6:0]   alu_opcode;
  logic [2:0]   alu_funct3;
  logic [6:0]   alu_funct7;
  logic [31:0]  alu_op1;
  logic [31:0]  alu_op2;
  logic [31:0]  alu_rez;
  logic         rsp_valid;
  logic [1:0]   rsp_tid;
  logic [31:0]  rsp_data;
  logic         rsp_ready = 1'b1;
  logic [31:0]  stat_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  rv_alu_arbiter #(.NTHREADS(4), .TID_W(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_op1(req_op1), .req_op2(req_op2), .gnt(gnt),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_rez(alu_rez),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  // Minimal ALU stand-in: ADD/SUB for OP, ADDI for OP-IMM, funct3=0 only.
  always_comb begin
    alu_rez = 32'd0;
    if (alu_funct3 == 3'd0) begin
      if (alu_opcode == 7'h33)
        alu_rez = (alu_funct7 == 7'h20) ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
      else if (alu_opcode == 7'h13)
        alu_rez = alu_op1 + alu_op2;
    end
  end

  typedef struct {
    logic        rst_before;
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  gnt;
    logic        rv;
    logic [1:0]  tid;
    logic [31:0] data;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [40];
  int   n_vec = 0;

  task automatic add(input logic rb, input logic [3:0] rq, input logic rdy,
                     input logic [3:0] g, input logic rv, input logic [1:0] tid,
                     input logic [31:0] data, input logic [31:0] cnt);
    tbl[n_vec] = '{rb, rq, rdy, g, rv, tid, data, cnt};
    n_vec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    // Thread fields: t0 ADD 100+1, t1 ADD 3+2, t2 ADDI 3+5, t3 ADD 7+9.
    req_opcode = {7'h33, 7'h13, 7'h33, 7'h33};
    req_funct3 = '0;
    req_funct7 = '0;
    req_op1    = {32'd7, 32'd3, 32'd3, 32'd100};
    req_op2    = {32'd9, 32'd5, 32'd2, 32'd1};

    // Single ADD from thread 1.
    add(1, 4'b0010, 1, 4'b0010, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 5, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
    // All four requesting continuously.
    add(1, 4'b1111, 1, 4'b0001, 0, 0, 0,   0);
    add(0, 4'b1111, 1, 4'b0010, 0, 0, 0,   0);
    add(0, 4'b1111, 1, 4'b0100, 1, 0, 101, 0);
    add(0, 4'b1111, 1, 4'b1000, 1, 1, 5,   0);
    add(0, 4'b1111, 1, 4'b0001, 1, 2, 8,   0);
    add(0, 4'b1111, 1, 4'b0010, 1, 3, 16,  0);
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 101, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 5,   0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0,   0);
    // rr_last=0 with threads 0 and 2: thread 2 wins first.
    add(1, 4'b0001, 1, 4'b0001, 0, 0, 0,   0);
    add(0, 4'b0101, 1, 4'b0100, 0, 0, 0,   0);
    add(0, 4'b0001, 1, 4'b0001, 1, 0, 101, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 2, 8,   0);
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 101, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0,   0);
    // Thread 2 ADDI, writeback stalls 3 cycles while thread 3 waits.
    add(1, 4'b0100, 0, 4'b0100, 0, 0, 0,  0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0,  0);
    add(0, 4'b1000, 0, 4'b0000, 1, 2, 8,  0);
    add(0, 4'b1000, 0, 4'b0000, 1, 2, 8,  1);
    add(0, 4'b1000, 0, 4'b0000, 1, 2, 8,  2);
    add(0, 4'b1000, 1, 4'b1000, 1, 2, 8,  3);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0,  3);
    add(0, 4'b0000, 1, 4'b0000, 1, 3, 16, 3);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0,  3);

    for (int v = 0; v < n_vec; v++) begin
      if (tbl[v].rst_before) begin
        do_reset();
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end else begin
        @(negedge clk);
      end
      req       = tbl[v].req;
      rsp_ready = tbl[v].rdy;
      #2;
`ifdef RV_ALU_ARB_STATS_EN
      exp_cnt = tbl[v].cnt;
`else
      exp_cnt = 32'd0;
`endif
      check($sformatf("gnt[%0d]", v), {28'd0, gnt}, {28'd0, tbl[v].gnt});
      check($sformatf("rsp_valid[%0d]", v), {31'd0, rsp_valid}, {31'd0, tbl[v].rv});
      if (tbl[v].rv) begin
        check($sformatf("rsp_tid[%0d]", v), {30'd0, rsp_tid}, {30'd0, tbl[v].tid});
        check($sformatf("rsp_data[%0d]", v), rsp_data, tbl[v].data);
      end
      check($sformatf("stall_cnt[%0d]", v), stat_stall_cnt, exp_cnt);
    end

    // Async reset mid-cycle with both stages full.
    do_reset();
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("pre_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("pre_rst_alu_op1", alu_op1, 32'd3);
    rst = 1'b1;
    #1;
    check("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_gnt", {28'd0, gnt}, 32'd0);
    check("async_alu_op1", alu_op1, 32'd0);
    check("async_alu_opcode", {25'd0, alu_opcode}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0001;
    #2;
    check("post_rst_gnt", {28'd0, gnt}, 32'd1);
    @(negedge clk);
    req = 4'b0000;
    #2;
    check("post_rst_no_stale", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #2;
    check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("post_rst_rsp_tid", {30'd0, rsp_tid}, 32'd0);
    check("post_rst_rsp_data", rsp_data, 32'd101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
